// File: rtl/fifo_enq_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO enqueue port between NUM_REQ producers.
// Optional per-requester statistics are enabled by defining FIFO_ARB_STATS_EN.
module fifo_enq_arbiter #(
  parameter int WIDTH     = 512,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_wrreq,
  output logic [WIDTH-1:0]             fifo_data,
  input  logic                         fifo_full,
  output logic                         grant_active,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]        stat_beats,
  output logic [31:0]                  stat_forced
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [IW-1:0]   last_owner_reg, last_owner_next;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic            stage_valid_reg;
  logic [WIDTH-1:0] stage_data_reg;

  logic [IW-1:0]   pick;
  logic            any_valid;
  logic            stage_accept, xfer, at_max, burst_end;
  logic            owner_valid, owner_last;
  logic [WIDTH-1:0] owner_data;

  assign owner_valid  = req_valid[owner_reg];
  assign owner_last   = req_last[owner_reg];
  assign owner_data   = req_data[owner_reg*WIDTH +: WIDTH];
  assign stage_accept = !stage_valid_reg || !fifo_full;
  assign xfer         = (state_reg == BURST) && owner_valid && stage_accept;
  assign at_max       = (beat_cnt_reg == CW'(MAX_BURST - 1));
  assign burst_end    = xfer && (owner_last || at_max);

  // First valid requester at or after last_owner+1, wrapping around.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    pick      = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(last_owner_reg) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        pick      = cand;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          owner_next    = pick;
          beat_cnt_next = '0;
          state_next    = BURST;
        end
      end
      BURST: begin
        if (xfer) beat_cnt_next = beat_cnt_reg + 1'b1;
        if (burst_end) begin
          last_owner_next = owner_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      last_owner_reg  <= IW'(NUM_REQ - 1);
      beat_cnt_reg    <= '0;
      stage_valid_reg <= 1'b0;
      stage_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      // The stage holds its beat while the FIFO is full; otherwise it drains and refills together.
      if (stage_accept) begin
        stage_valid_reg <= xfer;
        if (xfer) stage_data_reg <= owner_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == BURST) && (owner_reg == IW'(gi)) && stage_accept;
    end
  endgenerate

  assign fifo_wrreq   = stage_valid_reg;
  assign fifo_data    = stage_data_reg;
  assign grant_active = (state_reg == BURST);
  assign grant_id     = owner_reg;

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] stat_beats_reg [NUM_REQ];
  logic [31:0] stat_forced_reg;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stat_beats_reg[gi] <= '0;
        else if (req_valid[gi] && req_ready[gi]) stat_beats_reg[gi] <= stat_beats_reg[gi] + 32'd1;
      end
      assign stat_beats[gi*32 +: 32] = stat_beats_reg[gi];
    end
  endgenerate

  // A burst that ends on its own last beat at MAX_BURST is not a forced rotation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stat_forced_reg <= '0;
    else if (xfer && at_max && !owner_last) stat_forced_reg <= stat_forced_reg + 32'd1;
  end
  assign stat_forced = stat_forced_reg;
`endif

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter: single burst, round-robin, forced rotation,
// backpressure and asynchronous reset mid-burst.
module tb_fifo_enq_arbiter;
  localparam int W  = 16;
  localparam int NR = 4;
  localparam int MB = 8;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            fifo_wrreq;
  logic [W-1:0]    fifo_data;
  logic            fifo_full;
  logic            grant_active;
  logic [1:0]      grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*32-1:0] stat_beats;
  logic [31:0]      stat_forced;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] wq[$];

  fifo_enq_arbiter #(.WIDTH(W), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_full(fifo_full),
    .grant_active(grant_active), .grant_id(grant_id)
`ifdef FIFO_ARB_STATS_EN
    , .stat_beats(stat_beats), .stat_forced(stat_forced)
`endif
  );

  always #5 clock = ~clock;

  // Record every completed FIFO write, one line per transaction.
  always @(negedge clock) begin
    if (reset_n && fifo_wrreq && !fifo_full) begin
      wq.push_back(fifo_data);
      $display("write t=%0t data=%0h", $time, fifo_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_id, k0, k, cyc;
    bit side_done, x0, x1;
    logic [W-1:0] exp_q[$];

    reset_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_gact", grant_active, 0);
    chk("rst_gid", grant_id, 0);
    reset_n = 1'b1;

    // Single requester 2: beats A, B, C(last)
    req_valid = 4'b0100; req_data[2*W +: W] = 16'hA; req_last = '0;
    #1;
    chk("s_c0_gact", grant_active, 0);
    chk("s_c0_ready", req_ready, 0);
    tick();
    chk("s_c1_gact", grant_active, 1);
    chk("s_c1_gid", grant_id, 2);
    chk("s_c1_ready", req_ready, 4'b0100);
    tick();
    req_data[2*W +: W] = 16'hB;
    chk("s_c2_wr", fifo_wrreq, 1);
    chk("s_c2_data", fifo_data, 16'hA);
    tick();
    req_data[2*W +: W] = 16'hC; req_last = 4'b0100;
    chk("s_c3_data", fifo_data, 16'hB);
    chk("s_c3_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0; req_last = '0;
    chk("s_c4_wr", fifo_wrreq, 1);
    chk("s_c4_data", fifo_data, 16'hC);
    chk("s_c4_gact", grant_active, 0);
    chk("s_c4_gid", grant_id, 2);
    tick();
    chk("s_c5_wr", fifo_wrreq, 0);

    // Round-robin, one-beat bursts from everyone; last owner was 2 so 3 goes first
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = W'(16'h10 + i);
    exp_id = 3;
    for (int g = 0; g < 8; g++) begin
      tick();
      chk("rr_gact", grant_active, 1);
      chk("rr_gid", grant_id, exp_id);
      chk("rr_ready", req_ready, 4'b0001 << exp_id);
      tick();
      chk("rr_idle", grant_active, 0);
      chk("rr_data", fifo_data, 16'h10 + exp_id);
      exp_id = (exp_id + 1) % NR;
    end
    req_valid = '0; req_last = '0;
    tick();

    // Forced rotation: req 0 sends 20 beats, req 1 one beat meanwhile
    wq.delete();
    k0 = 0; side_done = 0; cyc = 0;
    while ((k0 < 20 || !side_done) && cyc < 80) begin
      req_valid = {2'b00, !side_done, (k0 < 20)};
      req_data[0 +: W] = W'(16'h100 + k0);
      req_data[W +: W] = 16'h200;
      req_last = {2'b00, 1'b1, (k0 == 19)};
      #1;
      x0 = req_valid[0] && req_ready[0];
      x1 = req_valid[1] && req_ready[1];
      tick();
      if (x0) k0++;
      if (x1) side_done = 1;
      cyc++;
    end
    req_valid = '0; req_last = '0;
    tick(); tick();
    chk("rot_done", (cyc < 80), 1);
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(16'h100 + i));
    exp_q.push_back(16'h200);
    for (int i = 8; i < 20; i++) exp_q.push_back(W'(16'h100 + i));
    chk("rot_count", wq.size(), 21);
    for (int i = 0; i < 21; i++) chk("rot_order", (i < wq.size()) ? wq[i] : 'x, exp_q[i]);
`ifdef FIFO_ARB_STATS_EN
    chk("stat_beats0", stat_beats[31:0], 22);
    chk("stat_forced", stat_forced, 2);
`endif

    // Backpressure: req 1 sends 6 beats, FIFO full for cycles 4..8
    wq.delete(); exp_q.delete();
    k = 0; cyc = 0;
    while (k < 6 && cyc < 60) begin
      fifo_full = (cyc >= 4 && cyc < 9);
      req_valid = {2'b00, (k < 6), 1'b0};
      req_data[W +: W] = W'(16'h300 + k);
      req_last = {2'b00, (k == 5), 1'b0};
      #1;
      if (fifo_full) begin
        chk("bp_ready", req_ready, 0);
        chk("bp_wrreq", fifo_wrreq, 1);
        chk("bp_data", fifo_data, 16'h302);
      end
      x1 = req_valid[1] && req_ready[1];
      tick();
      if (x1) k++;
      cyc++;
    end
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
    tick(); tick();
    chk("bp_done", (cyc < 60), 1);
    chk("bp_count", wq.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_order", (i < wq.size()) ? wq[i] : 'x, 16'h300 + i);

    // Reset while req 3 holds the grant with a beat in the stage
    req_valid = 4'b1000; req_data[3*W +: W] = 16'h400; req_last = '0;
    tick(); tick();
    chk("mr_gid", grant_id, 3);
    chk("mr_wrreq", fifo_wrreq, 1);
    chk("mr_gact", grant_active, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_rst_ready", req_ready, 0);
    chk("mr_rst_wrreq", fifo_wrreq, 0);
    chk("mr_rst_data", fifo_data, 0);
    chk("mr_rst_gact", grant_active, 0);
    chk("mr_rst_gid", grant_id, 0);
    req_valid = 4'b1001;
    #1;
    reset_n = 1'b1;
    tick();
    chk("mr_post_gid", grant_id, 0);
    chk("mr_post_ready", req_ready, 4'b0001);
    chk("mr_post_wrreq", fifo_wrreq, 0);
    req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
